// File: rtl/cmd_frame_parser.sv
// Byte-stream command frame parser: header, 7-byte payload, XOR checksum.
// Emits decoded opcode/address/data on a good frame and error pulses otherwise.
module cmd_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  output logic        err_csum,
  output logic        err_abort,
  output logic [7:0]  err_cnt
);

  localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StHunt, StPayload, StCsum} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [55:0]       shift_q, shift_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [15:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              err_csum_q, err_csum_d;
  logic              err_abort_q, err_abort_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cmd_valid_d = 1'b0;
    err_csum_d  = 1'b0;
    err_abort_d = 1'b0;

    unique case (state_q)
      StHunt: begin
        gap_d = '0;
        if (rx_valid && !rx_err && rx_byte == HDR_BYTE) begin
          state_d = StPayload;
          idx_d   = 3'd0;
          sum_d   = 8'h00;
        end
      end
      StPayload, StCsum: begin
        if (rx_valid) begin
          gap_d = '0;
          if (rx_err) begin
            err_abort_d = 1'b1;
            state_d     = StHunt;
          end else if (state_q == StPayload) begin
            shift_d = {shift_q[47:0], rx_byte};
            sum_d   = sum_q ^ rx_byte;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd6) state_d = StCsum;
          end else begin
            if (rx_byte == sum_q) begin
              opcode_d    = shift_q[55:48];
              addr_d      = shift_q[47:32];
              data_d      = shift_q[31:0];
              cmd_valid_d = 1'b1;
            end else begin
              err_csum_d = 1'b1;
            end
            state_d = StHunt;
          end
        end else if (gap_q == GapW'(TIMEOUT_CYCLES - 1)) begin
          // This idle cycle makes the gap reach TIMEOUT_CYCLES.
          err_abort_d = 1'b1;
          state_d     = StHunt;
          gap_d       = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase

    err_cnt_d = err_cnt_q;
    if ((err_csum_d || err_abort_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      idx_q       <= 3'd0;
      sum_q       <= 8'h00;
      gap_q       <= '0;
      shift_q     <= '0;
      opcode_q    <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 32'h0;
      cmd_valid_q <= 1'b0;
      err_csum_q  <= 1'b0;
      err_abort_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cmd_valid_q <= cmd_valid_d;
      err_csum_q  <= err_csum_d;
      err_abort_q <= err_abort_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_opcode = opcode_q;
  assign cmd_addr   = addr_q;
  assign cmd_data   = data_q;
  assign cmd_valid  = cmd_valid_q;
  assign err_csum   = err_csum_q;
  assign err_abort  = err_abort_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frames plus random traffic, compared every cycle
// against a byte-queue reference model of the frame rules.
module tb_cmd_frame_parser;

  localparam int unsigned TO  = 16;
  localparam logic [7:0]  HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid, err_csum, err_abort;
  logic [7:0]  err_cnt;

  cmd_frame_parser #(.TIMEOUT_CYCLES(TO), .HDR_BYTE(HDR)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .cmd_opcode (cmd_opcode),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .err_csum   (err_csum),
    .err_abort  (err_abort),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is the bytes collected after a header; judged when 8 are in.
  bit          m_in;
  logic [7:0]  m_q[$];
  int          m_gap;
  logic [7:0]  m_op;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  logic        m_cv, m_ec, m_ea;
  int          m_cnt;

  function automatic void model_reset();
    m_in = 0; m_q.delete(); m_gap = 0;
    m_op = 0; m_addr = 0; m_data = 0;
    m_cv = 0; m_ec = 0; m_ea = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] b, input logic e);
    logic [7:0] x;
    m_cv = 0; m_ec = 0; m_ea = 0;
    if (!m_in) begin
      if (v && !e && b == HDR) begin
        m_in = 1; m_q.delete(); m_gap = 0;
      end
    end else if (v) begin
      m_gap = 0;
      if (e) begin
        m_ea = 1; m_in = 0;
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 8) begin
          x = 8'h00;
          for (int i = 0; i < 7; i++) x ^= m_q[i];
          if (x == m_q[7]) begin
            m_cv = 1; m_op = m_q[0]; m_addr = {m_q[1], m_q[2]};
            m_data = {m_q[3], m_q[4], m_q[5], m_q[6]};
          end else begin
            m_ec = 1;
          end
          m_in = 0;
        end
      end
    end else begin
      m_gap++;
      if (m_gap == TO) begin
        m_ea = 1; m_in = 0;
      end
    end
    if ((m_ec || m_ea) && m_cnt < 255) m_cnt++;
  endfunction

  task automatic compare_all();
    check("cmd_valid", 32'(cmd_valid), 32'(m_cv));
    check("err_csum", 32'(err_csum), 32'(m_ec));
    check("err_abort", 32'(err_abort), 32'(m_ea));
    check("err_excl", 32'(err_csum & err_abort), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check("opcode", 32'(cmd_opcode), 32'(m_op));
    check("addr", 32'(cmd_addr), 32'(m_addr));
    check("data", cmd_data, m_data);
    if (cmd_valid) n_cmd++;
  endtask

  // One clock: present inputs, advance model, compare just after the edge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic e);
    rx_valid = v; rx_byte = b; rx_err = e;
    model_step(v, b, e);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                            input logic [7:0] corrupt);
    logic [7:0] f[9];
    f[0] = HDR; f[1] = op; f[2] = a[15:8]; f[3] = a[7:0];
    f[4] = d[31:24]; f[5] = d[23:16]; f[6] = d[15:8]; f[7] = d[7:0];
    f[8] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6] ^ f[7] ^ corrupt;
    for (int i = 0; i < 9; i++) send(f[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_err = 1'b0; rx_byte = 8'h00;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  int cmd_before;

  initial begin
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Golden frame, then bad checksum.
    send_frame(8'h01, 16'h0002, 32'h12345678, 8'h00);
    idle(1);
    check("golden_op", 32'(cmd_opcode), 32'h01);
    check("golden_data", cmd_data, 32'h12345678);
    send_frame(8'h01, 16'h0002, 32'h12345678, 8'h07);
    idle(1);
    check("bad_csum_cnt", 32'(err_cnt), 32'd1);

    // Noise then a frame with header bytes inside the payload.
    begin
      logic [7:0] s[11];
      s = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h04};
      for (int i = 0; i < 11; i++) send(s[i]);
    end
    idle(1);
    check("embedded_hdr_data", cmd_data, 32'hA5A5A5A5);

    // Timeout: 15 idle cycles survive, 16 abort.
    send(HDR); send(8'h01); idle(TO - 1); send(8'h00); idle(TO); idle(1);
    send_frame(8'h33, 16'hBEEF, 32'hCAFEF00D, 8'h00);
    idle(1);
    check("post_timeout_addr", 32'(cmd_addr), 32'hBEEF);

    // Back-to-back frames, then reset in the middle of a third.
    cmd_before = n_cmd;
    send_frame(8'h10, 16'h1111, 32'h11111111, 8'h00);
    send_frame(8'h20, 16'h2222, 32'h22222222, 8'h00);
    send(HDR); send(8'h30); send(8'h33);
    check("b2b_count", 32'(n_cmd - cmd_before), 32'd2);
    do_reset();
    idle(TO + 2);

    // rx_err on the 5th byte, repeated until the counter saturates.
    for (int k = 0; k < 256; k++) begin
      send(HDR); send(8'h01); send(8'h02); send(8'h03);
      cyc(1'b1, 8'h04, 1'b1);
    end
    idle(1);
    check("cnt_saturated", 32'(err_cnt), 32'hFF);
    do_reset();

    // Random traffic: gaps, line errors, corruptions, noise, near-timeout idles.
    for (int k = 0; k < 300; k++) begin
      logic [7:0]  op, corrupt;
      logic [15:0] a;
      logic [31:0] d;
      op = 8'($urandom); a = 16'($urandom); d = $urandom;
      corrupt = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 9) == 0) begin
        send(HDR);
        for (int i = 0; i < 9; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, TO + 1));
          cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 5) == 0));
        end
      end else begin
        send_frame(op, a, d, corrupt);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, TO + 2));
      if ($urandom_range(0, 4) == 0) cyc(1'b1, 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 50) == 0) do_reset();
    end
    idle(TO + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
